// File: rtl/io_cfg_ctrl_if.sv
// Host-side request/response bundle for the pad-control register block.
// Handshake: a request transfers on a posedge where req_valid & req_ready; the
// host keeps req_valid and payload stable until then. rsp_valid is a one-cycle
// pulse with no backpressure. dbg_state mirrors the controller FSM.
interface io_cfg_ctrl_if #(
  parameter int SIDEW = 2,
  parameter int PINW  = 4,
  parameter int CFGW  = 18
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_bcast;
  logic              req_commit;
  logic [SIDEW-1:0]  req_side;
  logic [PINW-1:0]   req_pin;
  logic [CFGW+1:0]   req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [CFGW+1:0]   rsp_rdata;
  logic              busy;
  logic [1:0]        dbg_state;

  modport master (
    output req_valid, req_write, req_bcast, req_commit, req_side, req_pin, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, busy, dbg_state
  );

  modport slave (
    input  req_valid, req_write, req_bcast, req_commit, req_side, req_pin, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, busy, dbg_state
  );
endinterface

// File: rtl/io_cfg_ctrl.sv
// Pad-control register block: host writes land in a shadow bank, and a commit copies
// the whole shadow bank into the active bank that drives the padring in a single edge.
module io_cfg_ctrl #(
  parameter int              NSIDES   = 4,
  parameter int              NPINS    = 9,
  parameter int              CFGW     = 18,
  parameter logic [CFGW-1:0] RESETCFG = '0,
  parameter int              PINW     = $clog2(NPINS),
  parameter int              SIDEW    = $clog2(NSIDES)
) (
  input  logic                          clk,
  input  logic                          nreset,
  io_cfg_ctrl_if.slave                  bus,
  output logic [NSIDES*NPINS*CFGW-1:0]  io_cfg,
  output logic [NSIDES*NPINS-1:0]       io_ie,
  output logic [NSIDES*NPINS-1:0]       io_oen
);

  localparam int                DW       = CFGW + 2;
  // Word layout {cfg, ie, oen}; reset leaves every pad tristated with input off.
  localparam logic [DW-1:0]     RST_WORD = {RESETCFG, 1'b0, 1'b1};
  localparam logic [SIDEW:0]    SIDE_LIM = (SIDEW+1)'(NSIDES);
  localparam logic [PINW:0]     PIN_LIM  = (PINW+1)'(NPINS);
  localparam logic [PINW-1:0]   LAST_PIN = PINW'(NPINS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BCAST  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DW-1:0]     r_shadow [NSIDES][NPINS];
  logic [DW-1:0]     r_active [NSIDES][NPINS];
  logic [PINW-1:0]   r_cnt;
  logic [SIDEW-1:0]  r_bside;
  logic [DW-1:0]     r_bdata;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DW-1:0]     r_rsp_rdata;

  logic              w_accept;
  logic              w_side_ok;
  logic              w_addr_ok;
  logic              w_single_wr;
  logic              w_bcast_go;
  logic [DW-1:0]     w_rd_word;

  assign w_accept    = bus.req_valid && (r_state == S_IDLE);
  assign w_side_ok   = {1'b0, bus.req_side} < SIDE_LIM;
  assign w_addr_ok   = w_side_ok && ({1'b0, bus.req_pin} < PIN_LIM);
  assign w_single_wr = w_accept && !bus.req_commit && bus.req_write && !bus.req_bcast && w_addr_ok;
  assign w_bcast_go  = w_accept && !bus.req_commit && bus.req_write && bus.req_bcast && w_side_ok;

  always_comb begin
    w_rd_word = '0;
    if (w_addr_ok) w_rd_word = r_shadow[bus.req_side][bus.req_pin];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && bus.req_commit) w_next = S_COMMIT;
        else if (w_bcast_go)            w_next = S_BCAST;
      end
      S_BCAST:  if (r_cnt == LAST_PIN) w_next = S_IDLE;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_cnt       <= '0;
      r_bside     <= '0;
      r_bdata     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && !bus.req_commit) begin
            if (bus.req_write && bus.req_bcast) begin
              if (w_side_ok) begin
                r_bside <= bus.req_side;
                r_bdata <= bus.req_wdata;
                r_cnt   <= '0;
              end else begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
              end
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= !w_addr_ok;
              if (!bus.req_write) r_rsp_rdata <= w_rd_word;
            end
          end
        end
        S_BCAST: begin
          if (r_cnt == LAST_PIN) begin
            r_cnt       <= '0;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + PINW'(1);
          end
        end
        S_COMMIT: r_rsp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int s = 0; s < NSIDES; s++)
        for (int p = 0; p < NPINS; p++)
          r_shadow[s][p] <= RST_WORD;
    end else if (w_single_wr) begin
      r_shadow[bus.req_side][bus.req_pin] <= bus.req_wdata;
    end else if (r_state == S_BCAST) begin
      r_shadow[r_bside][r_cnt] <= r_bdata;
    end
  end

  // The active bank only ever loads as a whole, so the padring sees one atomic change.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int s = 0; s < NSIDES; s++)
        for (int p = 0; p < NPINS; p++)
          r_active[s][p] <= RST_WORD;
    end else if (r_state == S_COMMIT) begin
      r_active <= r_shadow;
    end
  end

  for (genvar gs = 0; gs < NSIDES; gs++) begin : g_side
    for (genvar gp = 0; gp < NPINS; gp++) begin : g_pin
      assign io_cfg[(gs*NPINS+gp)*CFGW +: CFGW] = r_active[gs][gp][DW-1:2];
      assign io_ie[gs*NPINS+gp]                 = r_active[gs][gp][1];
      assign io_oen[gs*NPINS+gp]                = r_active[gs][gp][0];
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.dbg_state = r_state;

endmodule
